// File: rtl/shot_manager_if.sv
// Bundles the fire, frame, delete and shot-table signals between the ship,
// collision controller, renderer and the shot manager.
interface shot_manager_if #(
    parameter int MAX_SHOTS   = 10,
    parameter int ENTITY_SIZE = 34
);
    logic                             fire_valid;
    logic                             fire_ready;
    logic [9:0]                       fire_x;
    logic [9:0]                       fire_y;
    logic [2:0]                       fire_dir;
    logic                             frame_tick;
    logic                             delete_shot;
    logic [9:0]                       shot_address;
    logic [MAX_SHOTS*ENTITY_SIZE-1:0] shots;
    logic                             busy;
    logic                             fire_dropped;
    logic [3:0]                       active_count;

    modport master (
        output fire_valid, fire_x, fire_y, fire_dir, frame_tick,
               delete_shot, shot_address,
        input  fire_ready, shots, busy, fire_dropped, active_count
    );

    modport slave (
        input  fire_valid, fire_x, fire_y, fire_dir, frame_tick,
               delete_shot, shot_address,
        output fire_ready, shots, busy, fire_dropped, active_count
    );
endinterface

// File: rtl/shot_manager.sv
// Player shot table: spawns shots on fire, moves and ages every active shot
// once per frame with a one-slot-per-cycle scan, and clears deleted slots.
module shot_manager #(
    parameter int MAX_SHOTS   = 10,
    parameter int ENTITY_SIZE = 34,
    parameter int SHOT_SPEED  = 4,
    parameter int SHOT_LIFE   = 60
) (
    input  logic           clk,
    input  logic           reset_n,
    shot_manager_if.slave  sif
);
    localparam int IDX_W = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
    localparam logic [9:0]       SPEED   = 10'(SHOT_SPEED);
    localparam logic [7:0]       LIFE    = 8'(SHOT_LIFE);
    localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(MAX_SHOTS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   busy_q;

    logic [ENTITY_SIZE-1:0] slot_q [MAX_SHOTS];
    logic [ENTITY_SIZE-1:0] slot_d [MAX_SHOTS];
    logic                   fire_dropped_q, fire_dropped_d;
    logic [3:0]             active_count_q, active_count_d;

    logic                   fire_accept;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic [ENTITY_SIZE-1:0] new_rec;

    function automatic logic [9:0] step_x(input logic [2:0] dir, input logic [9:0] x);
        case (dir)
            3'd1, 3'd2, 3'd3: return x + SPEED;
            3'd5, 3'd6, 3'd7: return x - SPEED;
            default:          return x;
        endcase
    endfunction

    function automatic logic [9:0] step_y(input logic [2:0] dir, input logic [9:0] y);
        case (dir)
            3'd3, 3'd4, 3'd5: return y + SPEED;
            3'd7, 3'd0, 3'd1: return y - SPEED;
            default:          return y;
        endcase
    endfunction

    // One frame of motion and ageing; a shot on its last frame retires instead.
    function automatic logic [ENTITY_SIZE-1:0] advance(input logic [ENTITY_SIZE-1:0] rec);
        logic [ENTITY_SIZE-1:0] r;
        r = rec;
        if (rec[33:26] == 8'd1) begin
            r = '0;
        end else begin
            r[33:26] = rec[33:26] - 8'd1;
            r[15:6]  = step_x(rec[3:1], rec[15:6]);
            r[25:16] = step_y(rec[3:1], rec[25:16]);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.frame_tick) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx_q == LAST_IX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        fire_accept = sif.fire_valid && (state_q == IDLE);
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = MAX_SHOTS - 1; i >= 0; i--) begin
            if (!slot_q[i][0]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        new_rec        = '0;
        new_rec[0]     = 1'b1;
        new_rec[3:1]   = sif.fire_dir;
        new_rec[15:6]  = sif.fire_x;
        new_rec[25:16] = sif.fire_y;
        new_rec[33:26] = LIFE;

        fire_dropped_d = fire_accept && !free_found;
        active_count_d = '0;
        // Later writes win: delete overrides the scan update, which overrides fire.
        for (int i = 0; i < MAX_SHOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (fire_accept && free_found && (free_idx == IDX_W'(i)))
                slot_d[i] = new_rec;
            if ((state_q == SCAN) && (idx_q == IDX_W'(i)) && slot_q[i][0])
                slot_d[i] = advance(slot_q[i]);
            if (sif.delete_shot && (sif.shot_address == 10'(i)))
                slot_d[i] = '0;
            active_count_d = active_count_d + {3'b000, slot_d[i][0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_SHOTS; i++) slot_q[i] <= '0;
            fire_dropped_q <= 1'b0;
            active_count_q <= '0;
        end else begin
            slot_q         <= slot_d;
            fire_dropped_q <= fire_dropped_d;
            active_count_q <= active_count_d;
        end
    end

    assign sif.fire_ready   = (state_q == IDLE);
    assign sif.busy         = busy_q;
    assign sif.fire_dropped = fire_dropped_q;
    assign sif.active_count = active_count_q;

    for (genvar g = 0; g < MAX_SHOTS; g++) begin : g_pack
        assign sif.shots[g*ENTITY_SIZE +: ENTITY_SIZE] = slot_q[g];
    end
endmodule

// File: tb/tb_shot_manager.sv
// Bench for shot_manager: directed scenarios plus random traffic, checked every
// cycle against a slot-level behavioural model.
module tb_shot_manager;
    localparam int MS    = 10;
    localparam int ES    = 34;
    localparam int SPEED = 4;
    localparam int LIFE  = 60;
    localparam int VW    = MS * ES;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    shot_manager_if #(.MAX_SHOTS(MS), .ENTITY_SIZE(ES)) sif ();

    shot_manager #(.MAX_SHOTS(MS), .ENTITY_SIZE(ES), .SHOT_SPEED(SPEED), .SHOT_LIFE(LIFE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (sif)
    );

    always #5 clk = ~clk;

    // Behavioural model: one entry per slot, plus how many slots the scan still has to visit.
    int m_act  [MS];
    int m_dir  [MS];
    int m_x    [MS];
    int m_y    [MS];
    int m_life [MS];
    int m_scan_left = 0;
    int m_drop = 0;
    int dxs [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int dys [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic clear_slot(input int i);
        m_act[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0; m_life[i] = 0;
    endtask

    function automatic logic [VW-1:0] model_shots();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < MS; i++)
            v[i*ES +: ES] = {8'(m_life[i]), 10'(m_y[i]), 10'(m_x[i]), 2'b00, 3'(m_dir[i]), 1'(m_act[i])};
        return v;
    endfunction

    function automatic int model_count();
        int c;
        c = 0;
        for (int i = 0; i < MS; i++) c += m_act[i];
        return c;
    endfunction

    task automatic model_step();
        int f;
        int s;
        if (!reset_n) begin
            for (int i = 0; i < MS; i++) clear_slot(i);
            m_scan_left = 0;
            m_drop = 0;
        end else begin
            m_drop = 0;
            if (m_scan_left == 0) begin
                if (sif.fire_valid) begin
                    f = -1;
                    for (int i = 0; i < MS; i++) if (f < 0 && m_act[i] == 0) f = i;
                    if (f >= 0) begin
                        m_act[f] = 1; m_dir[f] = int'(sif.fire_dir);
                        m_x[f] = int'(sif.fire_x); m_y[f] = int'(sif.fire_y); m_life[f] = LIFE;
                    end else begin
                        m_drop = 1;
                    end
                end
                if (sif.frame_tick) m_scan_left = MS;
            end else begin
                s = MS - m_scan_left;
                if (m_act[s] != 0) begin
                    if (m_life[s] == 1) clear_slot(s);
                    else begin
                        m_life[s] = m_life[s] - 1;
                        m_x[s] = (m_x[s] + dxs[m_dir[s]] * SPEED + 1024) % 1024;
                        m_y[s] = (m_y[s] + dys[m_dir[s]] * SPEED + 1024) % 1024;
                    end
                end
                m_scan_left = m_scan_left - 1;
            end
            if (sif.delete_shot && int'(sif.shot_address) < MS) clear_slot(int'(sif.shot_address));
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
    initial begin
        for (int i = 0; i < MS; i++) clear_slot(i);
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("shots", sif.shots, model_shots());
            chk("busy", VW'(sif.busy), VW'(m_scan_left != 0));
            chk("fire_ready", VW'(sif.fire_ready), VW'(m_scan_left == 0));
            chk("fire_dropped", VW'(sif.fire_dropped), VW'(m_drop));
            chk("active_count", VW'(sif.active_count), VW'(model_count()));
            model_step();
        end
    end

    task automatic step(input bit fv, input int fx, input int fy, input int fd,
                        input bit tk, input bit del, input int addr);
        @(posedge clk);
        #1;
        sif.fire_valid   = fv;
        sif.fire_x       = 10'(fx);
        sif.fire_y       = 10'(fy);
        sif.fire_dir     = 3'(fd);
        sif.frame_tick   = tk;
        sif.delete_shot  = del;
        sif.shot_address = 10'(addr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sif.fire_valid = 1'b0; sif.frame_tick = 1'b0; sif.delete_shot = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [VW-1:0] snap;
    int nb;

    initial begin
        sif.fire_valid = 1'b0; sif.fire_x = '0; sif.fire_y = '0; sif.fire_dir = '0;
        sif.frame_tick = 1'b0; sif.delete_shot = 1'b0; sif.shot_address = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("reset_shots", sif.shots, '0);
        chk("reset_busy", VW'(sif.busy), '0);
        chk("reset_ready", VW'(sif.fire_ready), VW'(1));
        chk("reset_count", VW'(sif.active_count), '0);

        step(1, 160, 120, 2, 0, 0, 0);
        idle(1);
        chk("fire_slot0", VW'(sif.shots[0 +: ES]), VW'({8'd60, 10'd120, 10'd160, 2'b00, 3'd2, 1'b1}));
        chk("fire_count", VW'(sif.active_count), VW'(1));

        step(0, 0, 0, 0, 1, 0, 0);
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 0, (k == 2), 0, 0);
            nb += int'(sif.busy);
        end
        chk("busy_cycles", VW'(nb), VW'(10));
        chk("move_slot0", VW'(sif.shots[0 +: ES]), VW'({8'd59, 10'd120, 10'd164, 2'b00, 3'd2, 1'b1}));

        for (int i = 1; i < MS; i++) step(1, 100 + i, 200, i % 8, 0, 0, 0);
        idle(1);
        snap = sif.shots;
        chk("full_count", VW'(sif.active_count), VW'(10));
        step(1, 7, 7, 1, 0, 0, 0);
        idle(1);
        chk("drop_pulse", VW'(sif.fire_dropped), VW'(1));
        chk("drop_unchanged", sif.shots, snap);
        idle(1);
        chk("drop_single", VW'(sif.fire_dropped), '0);

        step(1, 33, 44, 5, 0, 1, 3);
        idle(1);
        chk("del_slot3", VW'(sif.shots[3*ES +: ES]), '0);
        chk("del_fire_drop", VW'(sif.fire_dropped), VW'(1));
        chk("del_count", VW'(sif.active_count), VW'(9));
        step(1, 50, 60, 4, 0, 0, 0);
        idle(1);
        chk("refill_slot3", VW'(sif.shots[3*ES +: ES]), VW'({8'd60, 10'd60, 10'd50, 2'b00, 3'd4, 1'b1}));

        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 2, 300, 6, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(11);
        chk("wrap_slot0", VW'(sif.shots[0 +: ES]), VW'({8'd59, 10'd300, 10'd1022, 2'b00, 3'd6, 1'b1}));
        snap = sif.shots;
        step(0, 0, 0, 0, 0, 1, 12);
        idle(1);
        chk("del_out_of_range", sif.shots, snap);

        pulse_reset();
        reset_n = 1'b1;
        step(1, 500, 500, 0, 0, 0, 0);
        for (int f = 1; f <= LIFE; f++) begin
            step(0, 0, 0, 0, 1, 0, 0);
            idle(11);
            if (f == LIFE - 1)
                chk("life_last", VW'(sif.shots[0 +: ES]), VW'({8'd1, 10'd264, 10'd500, 2'b00, 3'd0, 1'b1}));
        end
        chk("life_expired", VW'(sif.shots[0 +: ES]), '0);
        chk("life_count", VW'(sif.active_count), '0);

        step(1, 10, 10, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(4);
        pulse_reset();
        chk("midscan_shots", sif.shots, '0);
        chk("midscan_busy", VW'(sif.busy), '0);
        chk("midscan_count", VW'(sif.active_count), '0);
        reset_n = 1'b1;

        for (int k = 0; k < 3000; k++)
            step(($urandom % 2) == 0, int'($urandom % 1024), int'($urandom % 1024), int'($urandom % 8),
                 ($urandom % 20) == 0, ($urandom % 8) == 0, int'($urandom % 16));
        idle(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
